// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary to packed BCD converter.
// Holds the last result stable for the downstream display scanner.
module bin2bcd_seq #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic [DIGITS*4-1:0]   bcd,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int SCR_W = DIGITS * 4;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int CAT_W = SCR_W + BIN_W;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t           state;
  logic [BIN_W-1:0] shreg;
  logic [SCR_W-1:0] scratch;
  logic [SCR_W-1:0] adj;
  logic [CAT_W-1:0] cat;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      bin_ext;
  logic             ovf_pend;

  assign bin_ext = 64'(bin);

  // Add-3 correction on every digit, all from the pre-shift value.
  always_comb begin
    adj = scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch[d*4 +: 4] >= 4'd5)
        adj[d*4 +: 4] = scratch[d*4 +: 4] + 4'd3;
    end
  end

  assign cat = {adj, shreg} << 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      bcd      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            shreg    <= bin;
            scratch  <= '0;
            cnt      <= '0;
            ovf_pend <= (bin_ext >= LIMIT);
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= cat[CAT_W-1:BIN_W];
          shreg   <= cat[BIN_W-1:0];
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) state <= FIN;
        end
        FIN: begin
          if (ovf_pend) begin
            bcd      <= {DIGITS{4'h9}};
            overflow <= 1'b1;
          end else begin
            bcd      <= scratch;
            overflow <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and reference-model checks for bin2bcd_seq.
// Covers latency, overflow saturation, busy-ignore, reset abort.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] bin;
  logic [31:0] bcd;
  logic        busy;
  logic        done;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;

  bin2bcd_seq #(.BIN_W(32), .DIGITS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bin      (bin),
    .bcd      (bcd),
    .busy     (busy),
    .done     (done),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_bcd(input longint unsigned v);
    logic [31:0] r;
    longint unsigned t;
    if (v >= 64'd100000000) return 32'h99999999;
    r = '0;
    t = v;
    for (int d = 0; d < 8; d++) begin
      r[d*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Launch one conversion and wait for done (bounded).
  task automatic conv(input  logic [31:0] v,
                      output logic [31:0] b,
                      output logic        o,
                      output int          lat,
                      output int          bcnt,
                      output logic        stable);
    logic [31:0] held;
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    bin    = 32'hDEADBEEF;
    lat    = 0;
    bcnt   = 0;
    held   = bcd;
    stable = 1'b1;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      if (bcd !== held) stable = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    b = bcd;
    o = overflow;
  endtask

  logic [31:0] b;
  logic        o;
  logic        st;
  int          lat;
  int          bc;
  int          ndone;
  logic [31:0] dv [6];
  logic [31:0] de [6];
  logic        dov [6];

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    #1;
    check("rst_bcd", 64'(bcd), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_ovf", 64'(overflow), 64'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // zero value: latency and busy window
    conv(32'd0, b, o, lat, bc, st);
    check("zero_lat", 64'(lat), 64'd33);
    check("zero_busy", 64'(bc), 64'd33);
    check("zero_bcd", 64'(b), 64'h0);
    check("zero_ovf", 64'(o), 64'h0);
    @(posedge clk);
    #1;
    check("done_pulse", 64'(done), 64'h0);

    dv[0] = 32'd12345678;  de[0] = 32'h12345678; dov[0] = 1'b0;
    dv[1] = 32'd99999999;  de[1] = 32'h99999999; dov[1] = 1'b0;
    dv[2] = 32'd100000000; de[2] = 32'h99999999; dov[2] = 1'b1;
    dv[3] = 32'hFFFFFFFF;  de[3] = 32'h99999999; dov[3] = 1'b1;
    dv[4] = 32'd1;         de[4] = 32'h00000001; dov[4] = 1'b0;
    dv[5] = 32'd90817;     de[5] = 32'h00090817; dov[5] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      conv(dv[i], b, o, lat, bc, st);
      check($sformatf("dir%0d_bcd", i), 64'(b), 64'(de[i]));
      check($sformatf("dir%0d_ovf", i), 64'(o), 64'(dov[i]));
    end

    // start while busy is ignored; bin changes have no effect
    @(negedge clk);
    bin   = 32'd42;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    ndone = 0;
    while (!done && lat < 100) begin
      if (lat >= 4 && lat < 20) begin
        start = 1'b1;
        bin   = 32'd7 + 32'(lat);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (done) ndone++;
    end
    start = 1'b0;
    check("ign_lat", 64'(lat), 64'd33);
    check("ign_ndone", 64'(ndone), 64'd1);
    check("ign_bcd", 64'(bcd), 64'h42);
    // back-to-back: start lands in the done cycle
    conv(32'd7, b, o, lat, bc, st);
    check("b2b_lat", 64'(lat), 64'd33);
    check("b2b_bcd", 64'(b), 64'h7);

    // asynchronous reset aborts a conversion in flight
    conv(32'd12345678, b, o, lat, bc, st);
    check("pre_rst_bcd", 64'(b), 64'h12345678);
    @(negedge clk);
    bin   = 32'd555;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_bcd", 64'(bcd), 64'h0);
    check("arst_busy", 64'(busy), 64'h0);
    check("arst_done", 64'(done), 64'h0);
    check("arst_ovf", 64'(overflow), 64'h0);
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("arst_nodone", 64'(ndone), 64'd0);
    conv(32'd9, b, o, lat, bc, st);
    check("post_rst_bcd", 64'(b), 64'h9);

    // sweep plus random against the decimal reference
    for (int v = 0; v < 1000; v++) begin
      conv(32'(v), b, o, lat, bc, st);
      check($sformatf("sw%0d", v), {31'(0), st, b}, {32'h1, ref_bcd(64'(v))});
    end
    for (int i = 0; i < 300; i++) begin
      logic [31:0] r;
      r = $urandom_range(99999999, 0);
      conv(r, b, o, lat, bc, st);
      check($sformatf("rnd%0d", r), {31'(0), st, b}, {32'h1, ref_bcd(64'(r))});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
